// File: rtl/valu_oprnd_queue_if.sv
// Operand queue handshake bundle between the operand fetch stage (master)
// and the VALU operand queue (slave).
interface valu_oprnd_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush,
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  full,
        input  empty,
        input  almost_full,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  flush,
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output rd_valid,
        output full,
        output empty,
        output almost_full,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/valu_oprnd_queue.sv
// VALU operand queue: pointer-based circular buffer with registered read data,
// occupancy count, status decodes, synchronous flush and sticky error flags.
module valu_oprnd_queue #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 5,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    valu_oprnd_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointer increment with wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              empty_s;
    logic              full_s;
    logic              almost_full_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Status flags decode the registered count only, never the pointers.
    always_comb begin
        empty_s       = 1'b0;
        full_s        = 1'b0;
        almost_full_s = 1'b0;
        if (count_r == {CNT_W{1'b0}}) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
        if (count_r == CNT_W'(DEPTH)) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (count_r >= CNT_W'(AF_LEVEL)) begin
            almost_full_s = 1'b1;
        end else begin
            almost_full_s = 1'b0;
        end
    end

    // Acceptance: a full queue still takes a write when a read leaves in the same
    // cycle; flush swallows both requests without raising any flag.
    always_comb begin
        rd_acc_s  = 1'b0;
        wr_acc_s  = 1'b0;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        if (q.flush) begin
            rd_acc_s  = 1'b0;
            wr_acc_s  = 1'b0;
            ovf_set_s = 1'b0;
            udf_set_s = 1'b0;
        end else begin
            rd_acc_s  = q.rd_en & ~empty_s;
            wr_acc_s  = q.wr_en & (~full_s | rd_acc_s);
            ovf_set_s = q.wr_en & ~wr_acc_s;
            udf_set_s = q.rd_en & ~rd_acc_s;
        end
    end

    // Next occupancy from the accepted operations.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= q.wr_data;
        end
    end

    // Pointers, count, read data and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            rd_data_r   <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (q.flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (rd_acc_s) begin
                rd_ptr_r  <= ptr_next(rd_ptr_r);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            rd_valid_r  <= rd_acc_s;
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_r | ovf_set_s;
            underflow_r <= underflow_r | udf_set_s;
        end
    end

    assign q.rd_data     = rd_data_r;
    assign q.rd_valid    = rd_valid_r;
    assign q.count       = count_r;
    assign q.full        = full_s;
    assign q.empty       = empty_s;
    assign q.almost_full = almost_full_s;
    assign q.overflow    = overflow_r;
    assign q.underflow   = underflow_r;
endmodule

// File: tb/tb_valu_oprnd_queue.sv
// Randomized and directed bench for valu_oprnd_queue against a queue-based model.
module tb_valu_oprnd_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 5;
    localparam int AF_LVL = DEPTH - 1;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    logic [DATA_W-1:0] m_q [$];
    logic [DATA_W-1:0] exp_rd_data;
    logic              exp_rd_valid;
    logic              exp_ovf;
    logic              exp_udf;

    valu_oprnd_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) vif ();

    valu_oprnd_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests = n_tests + 1;
        if (obs !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_rd_data  = 32'h0;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
    endtask

    task automatic check_all(input string where);
        int sz;
        sz = m_q.size();
        check({where, ".count"},    32'(vif.count), 32'(sz));
        check({where, ".empty"},    32'(vif.empty), 32'(sz == 0));
        check({where, ".full"},     32'(vif.full), 32'(sz == DEPTH));
        check({where, ".afull"},    32'(vif.almost_full), 32'(sz >= AF_LVL));
        check({where, ".rd_valid"}, 32'(vif.rd_valid), 32'(exp_rd_valid));
        check({where, ".rd_data"},  vif.rd_data, exp_rd_data);
        check({where, ".overflow"}, 32'(vif.overflow), 32'(exp_ovf));
        check({where, ".underflow"},32'(vif.underflow), 32'(exp_udf));
    endtask

    // One clock: model the cycle from the inputs held across the edge, then compare.
    task automatic step(input string where);
        bit rd_ok;
        bit wr_ok;
        @(posedge clk);
        #1;
        if (vif.flush) begin
            m_q.delete();
            exp_rd_valid = 1'b0;
            exp_ovf      = 1'b0;
            exp_udf      = 1'b0;
        end else begin
            rd_ok = vif.rd_en && (m_q.size() > 0);
            wr_ok = vif.wr_en && ((m_q.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                exp_rd_data = m_q.pop_front();
            end
            exp_rd_valid = rd_ok;
            if (wr_ok) m_q.push_back(vif.wr_data);
            if (vif.wr_en && !wr_ok) exp_ovf = 1'b1;
            if (vif.rd_en && !rd_ok) exp_udf = 1'b1;
        end
        check_all(where);
    endtask

    task automatic cyc(input string where, input bit f, input bit w, input logic [31:0] wd, input bit r);
        vif.flush   = f;
        vif.wr_en   = w;
        vif.wr_data = wd;
        vif.rd_en   = r;
        step(where);
        vif.flush = 1'b0;
        vif.wr_en = 1'b0;
        vif.rd_en = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn        = 1'b0;
        vif.flush   = 1'b0;
        vif.wr_en   = 1'b0;
        vif.wr_data = 32'h0;
        vif.rd_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) begin
            cyc("fill", 1'b0, 1'b1, 32'h11 * (i + 1), 1'b0);
            if (i == 3) check("fill.af_at4", 32'(vif.almost_full), 32'h1);
        end
        check("fill.full", 32'(vif.full), 32'h1);
        check("fill.count5", 32'(vif.count), 32'h5);
        for (int i = 0; i < DEPTH; i++) begin
            cyc("drain", 1'b0, 1'b0, 32'h0, 1'b1);
            check("drain.data", vif.rd_data, 32'h11 * (i + 1));
        end
        check("drain.empty", 32'(vif.empty), 32'h1);

        // Wrap-around
        for (int i = 0; i < 3; i++) cyc("wrap.w", 1'b0, 1'b1, 32'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) cyc("wrap.r", 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("wrap.w2", 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc("wrap.r2", 1'b0, 1'b0, 32'h0, 1'b1);
            check("wrap.data", vif.rd_data, 32'hA0 + 32'(i));
        end

        // Full with simultaneous read and write
        for (int i = 0; i < 5; i++) cyc("fullrw.w", 1'b0, 1'b1, 32'(i + 1), 1'b0);
        cyc("fullrw.both", 1'b0, 1'b1, 32'h66, 1'b1);
        check("fullrw.data", vif.rd_data, 32'h1);
        check("fullrw.count", 32'(vif.count), 32'h5);
        check("fullrw.ovf", 32'(vif.overflow), 32'h0);
        for (int i = 0; i < 5; i++) cyc("fullrw.drain", 1'b0, 1'b0, 32'h0, 1'b1);
        check("fullrw.last", vif.rd_data, 32'h66);

        // Overflow and underflow
        for (int i = 0; i < 5; i++) cyc("ovf.w", 1'b0, 1'b1, 32'h30 + 32'(i), 1'b0);
        cyc("ovf.extra", 1'b0, 1'b1, 32'hEE, 1'b0);
        check("ovf.flag", 32'(vif.overflow), 32'h1);
        for (int i = 0; i < 5; i++) cyc("ovf.drain", 1'b0, 1'b0, 32'h0, 1'b1);
        cyc("udf.read", 1'b0, 1'b0, 32'h0, 1'b1);
        check("udf.flag", 32'(vif.underflow), 32'h1);
        check("udf.rdv", 32'(vif.rd_valid), 32'h0);
        cyc("flush", 1'b1, 1'b1, 32'h99, 1'b1);
        check("flush.ovf", 32'(vif.overflow), 32'h0);
        check("flush.udf", 32'(vif.underflow), 32'h0);

        // Empty with simultaneous read and write
        cyc("emptyrw.both", 1'b0, 1'b1, 32'h77, 1'b1);
        check("emptyrw.udf", 32'(vif.underflow), 32'h1);
        check("emptyrw.count", 32'(vif.count), 32'h1);
        cyc("emptyrw.read", 1'b0, 1'b0, 32'h0, 1'b1);
        check("emptyrw.data", vif.rd_data, 32'h77);
        cyc("emptyrw.flush", 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset mid-stream, asserted between edges with a read just completed
        for (int i = 0; i < 3; i++) cyc("rst.w", 1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
        cyc("rst.r", 1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        #2;
        rstn = 1'b1;
        cyc("rst.resume.w", 1'b0, 1'b1, 32'hD5, 1'b0);
        cyc("rst.resume.r", 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(99) < 3), ($urandom_range(99) < 60),
                $urandom, ($urandom_range(99) < 55));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/valu_oprnd_queue.md
Name: valu_oprnd_queue

Overview:
- Parametrised operand queue for the VPU vector ALU. It buffers lane operands between the operand fetch stage and the VALU.
- Circular buffer with registered read data, full/empty/almost-full status, an occupancy count, synchronous flush and sticky overflow/underflow flags.
- Supersedes the fixed 5-entry, 32-bit shift queue. There is no shifting and no sentinel values; occupancy is tracked by pointers.

Parameters:
- DATA_W, 32, width of each queued operand in bits.
- DEPTH, 5, number of entries. Must be >= 2; need not be a power of two.
- AF_LEVEL, DEPTH-1, count at or above which almost_full asserts. Legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1), width of count. Derived; not to be overridden.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue state.
- wr_en  in  1  enqueue request.
- wr_data  in  DATA_W  operand to enqueue.
- rd_en  in  1  dequeue request.
- rd_data  out  DATA_W  dequeued operand (registered).
- rd_valid  out  1  pulses for one cycle when rd_data holds a newly dequeued word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rstn low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_full = 0.
  - Storage array is not reset.
- Status outputs: full, empty and almost_full are combinational decodes of the registered count. They are never computed from the pointers.
- Acceptance, evaluated per cycle before any state update:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc).
  - A write into a full queue is therefore accepted when a read is accepted in the same cycle.
- Write: on wr_acc, mem[wr_ptr] <= wr_data. wr_ptr advances, wrapping from DEPTH-1 to 0.
- Read:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1, both visible the cycle after rd_en.
  - rd_ptr advances with the same wrap rule.
  - When there is no rd_acc, rd_valid <= 0 and rd_data holds its last value.
- Count update:
  - count <= count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Empty queue with simultaneous wr_en and rd_en:
  - The write is accepted; the read is rejected.
  - There is no write-to-read bypass. The word becomes readable on the following cycle.
- Error flags:
  - overflow <= 1 when wr_en & ~wr_acc.
  - underflow <= 1 when rd_en & ~rd_acc.
  - Both hold until flush or reset. Rejected operations change no other state.
- Flush (highest priority, synchronous):
  - Pointers, count, rd_valid, overflow and underflow all go to 0.
  - wr_en and rd_en in the same cycle are ignored; no flag is set for them.
  - rd_data holds its value.
- Reset asserted mid-operation aborts any in-flight read. rd_valid is 0 immediately on reset assertion.
- Latency:
  - Write to readable: 1 cycle (the entry is visible to rd_acc the cycle after the write edge).
  - rd_en to rd_data: 1 cycle.
- Throughput: one enqueue and one dequeue per cycle sustained, at any occupancy 1..DEPTH.

Test Plan:
- Fill and drain (DEPTH=5):
  - Stimulus: write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles.
  - Response: count reaches 5; full=1; almost_full asserts at count 4.
  - Then 5 reads: rd_data = 0x11..0x55 in order, each with a 1-cycle rd_valid pulse. Final state empty=1, count=0.
- Wrap-around:
  - Stimulus: write 3, read 3, then write 0xA0..0xA4 and read all.
  - Response: order is preserved across the pointer wrap and count never exceeds 5.
- Full with simultaneous read and write:
  - Stimulus: with the queue full of 1..5, assert wr_en=1 (0x66) and rd_en=1.
  - Response: rd_data=1 next cycle; count stays 5; overflow stays 0. A subsequent drain yields 2,3,4,5,0x66.
- Overflow and underflow:
  - Stimulus: write to a full queue with no read.
  - Response: overflow=1 and count unchanged. After draining, a read on empty sets underflow=1 with rd_valid=0.
  - Both flags stay set until flush; after flush both read 0 and count=0.
- Empty with simultaneous read and write:
  - Stimulus: on an empty queue, wr_en=1 (0x77) and rd_en=1.
  - Response: underflow=1, count=1, rd_valid=0. A read next cycle returns 0x77.
- Reset mid-stream:
  - Stimulus: after 3 writes and 1 read, pulse rstn low between clock edges.
  - Response: count=0, empty=1, rd_data=0 and rd_valid=0 immediately. Normal operation resumes on the first edge after release.
